// File: rtl/load_ext_unit.sv
// load_ext_unit
//   Load-data extraction/extension stage between data-memory read and
//   register-file writeback. Picks the byte/half/word/dword lane addressed
//   by in_addr, then sign- or zero-extends it to DATA_W. Results are queued
//   in a 2-entry FIFO so that full throughput holds under backpressure.
//
//   Optional feature macro: LOAD_EXT_ALIGN_CHECK_EN
//     undefined : low offset bits below the access size are forced to 0
//                 (force-aligned); out_err is constant 0.
//     defined   : misaligned requests are buffered in order with
//                 out_data=0, out_err=1.
//
// Ports
//   clk, rstn              clock (rising edge), synchronous active-low reset
//   in_valid/in_ready      request handshake
//   in_data                raw memory word, little-endian lanes
//   in_addr                byte offset within the word
//   in_size                0=byte 1=half 2=word 3=dword
//   in_sext                1=sign-extend, 0=zero-extend
//   in_tag                 destination tag, passed through
//   out_valid/out_ready    result handshake
//   out_data, out_tag      extended result and its tag
//   out_err                misalignment flag
module load_ext_unit #(
   parameter  int DATA_W = 32,
   parameter  int TAG_W  = 5,
   localparam int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [OFF_W-1:0]  in_addr,
   input  logic [1:0]        in_size,
   input  logic              in_sext,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err
);

   // ---------------- extraction / extension ----------------
   logic [1:0]        size_eff;
   logic [OFF_W-1:0]  low_mask;   // offset bits below the access size
   logic [OFF_W-1:0]  off;
   logic [DATA_W-1:0] lane;
   logic [DATA_W-1:0] fmask;      // ones over the field width
   logic              msb;
   logic [DATA_W-1:0] ext;
   logic [DATA_W-1:0] res_data;

   always_comb begin
      size_eff = in_size;
      // a 32-bit datapath has no dword; treat it as a word
      if (DATA_W == 32 && in_size == 2'd3) size_eff = 2'd2;

      low_mask = OFF_W'((32'd1 << size_eff) - 32'd1);
      off      = in_addr & ~low_mask;
      lane     = in_data >> {off, 3'b000};

      case (size_eff)
         2'd0:    begin fmask = DATA_W'(8'hFF);         msb = lane[7];        end
         2'd1:    begin fmask = DATA_W'(16'hFFFF);      msb = lane[15];       end
         2'd2:    begin fmask = DATA_W'(32'hFFFF_FFFF); msb = lane[31];       end
         default: begin fmask = '1;                     msb = lane[DATA_W-1]; end
      endcase

      // full-width fields have ~fmask == 0, so in_sext has no effect there
      ext = (lane & fmask) | ((in_sext && msb) ? ~fmask : '0);
   end

`ifdef LOAD_EXT_ALIGN_CHECK_EN
   logic misaligned;
   assign misaligned = (in_addr & low_mask) != '0;
   assign res_data   = misaligned ? '0 : ext;
`else
   assign res_data   = ext;
`endif

   // ---------------- 2-entry output FIFO ----------------
   logic [DATA_W-1:0] data_q [2];
   logic [TAG_W-1:0]  tag_q  [2];
   logic              rd_ptr, wr_ptr;
   logic [1:0]        count;
   logic              push, pop;

   // in_ready depends only on registered count and rstn, never on out_ready
   assign in_ready  = rstn && (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = data_q[rd_ptr];
   assign out_tag   = tag_q[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         if (push) begin
            data_q[wr_ptr] <= res_data;
            tag_q[wr_ptr]  <= in_tag;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

`ifdef LOAD_EXT_ALIGN_CHECK_EN
   logic err_q [2];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         err_q[0] <= 1'b0;
         err_q[1] <= 1'b0;
      end else if (push) begin
         err_q[wr_ptr] <= misaligned;
      end
   end

   assign out_err = err_q[rd_ptr];
`else
   assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_ext_unit.sv
module tb_load_ext_unit;

   localparam int DW = 32;
   localparam int TW = 5;

`ifdef LOAD_EXT_ALIGN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   // 32-bit instance
   logic          in_valid, in_ready, in_sext, out_valid, out_ready, out_err;
   logic [DW-1:0] in_data, out_data;
   logic [1:0]    in_addr, in_size;
   logic [TW-1:0] in_tag, out_tag;

   load_ext_unit #(.DATA_W(32), .TAG_W(TW)) u_dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_addr(in_addr), .in_size(in_size), .in_sext(in_sext), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_err(out_err)
   );

   // 64-bit instance
   logic          w_valid, w_in_ready, w_sext, w_out_valid, w_out_ready, w_err;
   logic [63:0]   w_data, w_out_data;
   logic [2:0]    w_addr;
   logic [1:0]    w_size;
   logic [TW-1:0] w_tag, w_out_tag;

   load_ext_unit #(.DATA_W(64), .TAG_W(TW)) u_dut64 (
      .clk(clk), .rstn(rstn),
      .in_valid(w_valid), .in_ready(w_in_ready), .in_data(w_data),
      .in_addr(w_addr), .in_size(w_size), .in_sext(w_sext), .in_tag(w_tag),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
      .out_tag(w_out_tag), .out_err(w_err)
   );

   typedef struct {
      logic [31:0]   data;
      logic [TW-1:0] tag;
      logic          err;
      logic          lat;   // check 1-cycle latency on pop
      int            pcyc;
   } exp_t;

   typedef struct {
      logic [31:0]   data;
      logic [1:0]    addr;
      logic [1:0]    size;
      logic          sext;
      logic [31:0]   exp;
      logic          err;
   } vec_t;

   exp_t sbq[$];
   exp_t cur;
   vec_t tbl[12];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // scoreboard monitor: sampled on the falling edge, handshakes complete at the next rise
   always @(negedge clk) begin
      exp_t e;
      if (rstn) begin
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL spurious_out: got tag %h expected no output", out_tag);
            end else begin
               e = sbq.pop_front();
               chk("out_data", out_data, e.data);
               chk("out_tag", out_tag, e.tag);
               chk("out_err", out_err, e.err);
               if (e.lat) chk("latency_cyc", cyc, e.pcyc);
            end
         end
         if (in_valid && in_ready) begin
            e = cur;
            e.pcyc = cyc + 1;
            sbq.push_back(e);
         end
      end
   end

   task automatic drive(input logic [31:0] d, input logic [1:0] a, input logic [1:0] sz,
                        input logic s, input logic [TW-1:0] t, input logic [31:0] ed,
                        input logic ee, input logic lat);
      in_data = d; in_addr = a; in_size = sz; in_sext = s; in_tag = t;
      cur.data = ed; cur.tag = t; cur.err = ee; cur.lat = lat; cur.pcyc = 0;
      in_valid = 1'b1;
   endtask

   // returns at posedge+#1 after the accepting edge
   task automatic wait_acc();
      int n = 0;
      @(negedge clk);
      while (!in_ready) begin
         n++;
         if (n > 50) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
            break;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic [1:0] a, input logic [1:0] sz,
                       input logic s, input logic [TW-1:0] t, input logic [31:0] ed,
                       input logic ee, input logic lat);
      drive(d, a, sz, s, t, ed, ee, lat);
      wait_acc();
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 30) begin @(posedge clk); n++; end
      #1;
      chk("drain_left", sbq.size(), 0);
   endtask

   // 64-bit single push with out_ready=1, result checked the cycle after accept
   task automatic push64_chk(input string name, input logic [63:0] d, input logic [2:0] a,
                             input logic [1:0] sz, input logic s, input logic [TW-1:0] t,
                             input logic [63:0] ed, input logic ee);
      w_data = d; w_addr = a; w_size = sz; w_sext = s; w_tag = t; w_valid = 1'b1;
      @(negedge clk); chk({name, "_rdy"}, w_in_ready, 1);
      @(posedge clk); #1; w_valid = 1'b0;
      @(negedge clk);
      chk({name, "_vld"}, w_out_valid, 1);
      chk({name, "_data"}, w_out_data, ed);
      chk({name, "_tag"}, w_out_tag, t);
      chk({name, "_err"}, w_err, ee);
      @(posedge clk); #1;
   endtask

   initial begin
      int c0;
      in_valid = 0; in_data = '0; in_addr = '0; in_size = '0; in_sext = 0; in_tag = '0;
      out_ready = 1;
      w_valid = 0; w_data = '0; w_addr = '0; w_size = '0; w_sext = 0; w_tag = '0;
      w_out_ready = 1;
      cur = '{data: '0, tag: '0, err: 1'b0, lat: 1'b0, pcyc: 0};

      tbl[0]  = '{32'h80FF_7F01, 2'd1, 2'd0, 1'b1, 32'h0000_007F, 1'b0};
      tbl[1]  = '{32'h80FF_7F01, 2'd2, 2'd0, 1'b1, 32'hFFFF_FFFF, 1'b0};
      tbl[2]  = '{32'h80FF_7F01, 2'd3, 2'd0, 1'b0, 32'h0000_0080, 1'b0};
      tbl[3]  = '{32'h80FF_7F01, 2'd0, 2'd0, 1'b1, 32'h0000_0001, 1'b0};
      tbl[4]  = '{32'h8001_1234, 2'd2, 2'd1, 1'b1, 32'hFFFF_8001, 1'b0};
      tbl[5]  = '{32'h8001_1234, 2'd2, 2'd1, 1'b0, 32'h0000_8001, 1'b0};
      tbl[6]  = '{32'h8001_1234, 2'd0, 2'd1, 1'b1, 32'h0000_1234, 1'b0};
      tbl[7]  = '{32'h8000_0000, 2'd0, 2'd2, 1'b1, 32'h8000_0000, 1'b0};
      tbl[8]  = '{32'h8000_0000, 2'd0, 2'd3, 1'b0, 32'h8000_0000, 1'b0};
      tbl[9]  = '{32'hDEAD_BEEF, 2'd2, 2'd2, 1'b0, CHK ? 32'h0 : 32'hDEAD_BEEF, CHK};
      tbl[10] = '{32'h8001_1234, 2'd3, 2'd1, 1'b1, CHK ? 32'h0 : 32'hFFFF_8001, CHK};
      tbl[11] = '{32'h8001_1234, 2'd1, 2'd1, 1'b0, CHK ? 32'h0 : 32'h0000_1234, CHK};

      // reset state
      repeat (2) @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_out_err", out_err, 0);
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", in_ready, 1);

      // table vectors, back to back with out_ready=1
      for (int i = 0; i < 12; i++)
         send(tbl[i].data, tbl[i].addr, tbl[i].size, tbl[i].sext, TW'(i),
              tbl[i].exp, tbl[i].err, 1'b1);
      drain();

      // backpressure: tags 3,4 fill the buffer, tag 5 stalls
      out_ready = 1'b0;
      send(32'h1122_3344, 2'd0, 2'd2, 1'b0, 5'd3, 32'h1122_3344, 1'b0, 1'b0);
      send(32'h5566_7788, 2'd2, 2'd1, 1'b0, 5'd4, 32'h0000_5566, 1'b0, 1'b0);
      drive(32'hCC00_0000, 2'd3, 2'd0, 1'b1, 5'd5, 32'hFFFF_FFCC, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_hold_data", out_data, 32'h1122_3344);
         chk("bp_hold_tag", out_tag, 5'd3);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_acc();
      drain();

      // streaming: 8 results on consecutive cycles, each 1 cycle after accept
      c0 = cyc;
      for (int i = 0; i < 8; i++)
         send(32'h0101_0101 * (i + 1), 2'd0, 2'd2, 1'b0, TW'(16 + i),
              32'h0101_0101 * (i + 1), 1'b0, 1'b1);
      chk("stream_cycles", cyc - c0, 8);
      drain();

      // 64-bit datapath
      push64_chk("w_word_sext", 64'hF000_0000_0000_0000, 3'd4, 2'd2, 1'b1, 5'd7,
                 64'hFFFF_FFFF_F000_0000, 1'b0);
      push64_chk("w_word_zext", 64'hF000_0000_0000_0000, 3'd4, 2'd2, 1'b0, 5'd8,
                 64'h0000_0000_F000_0000, 1'b0);
      push64_chk("w_dword_misal", 64'h0123_4567_89AB_CDEF, 3'd5, 2'd3, 1'b0, 5'd9,
                 CHK ? 64'h0 : 64'h0123_4567_89AB_CDEF, CHK);

      // reset with two buffered entries
      w_out_ready = 1'b0;
      w_data = 64'h1; w_addr = '0; w_size = 2'd3; w_sext = 0; w_tag = 5'd1; w_valid = 1'b1;
      @(posedge clk); #1; w_tag = 5'd2;
      @(posedge clk); #1; w_valid = 1'b0;
      @(negedge clk);
      chk("w_full_in_ready", w_in_ready, 0);
      chk("w_full_out_valid", w_out_valid, 1);
      @(posedge clk); #1;
      rstn = 1'b0;
      @(negedge clk);
      chk("w_rstlow_in_ready", w_in_ready, 0);
      @(posedge clk); #1;
      chk("w_rst_out_valid", w_out_valid, 0);
      chk("w_rst_out_data", w_out_data, 0);
      chk("w_rst_out_tag", w_out_tag, 0);
      rstn = 1'b1;
      w_out_ready = 1'b1;
      @(posedge clk); #1;
      chk("w_after_rst_out_valid", w_out_valid, 0);
      chk("w_after_rst_in_ready", w_in_ready, 1);
      chk("after_rst_out_valid", out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // absolute safety net
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule
